// File: rtl/test_trace_pkg.sv
// Shared state codes, trigger-mode codes and a width helper for the trace
// capture unit and anything that drives or inspects it.
package test_trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_POST  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [1:0] TM_MATCH    = 2'b00;
    localparam logic [1:0] TM_MISMATCH = 2'b01;
    localparam logic [1:0] TM_CHANGE   = 2'b10;
    localparam logic [1:0] TM_IMM      = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/test_trace_ram.sv
// Trace buffer storage: one synchronous write port, one registered read port
// with read-before-write behaviour on a shared address.
module test_trace_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/test_trace.sv
// Trace capture unit: circular sample buffer with programmable trigger and
// post-trigger count, frozen after capture for readout.
module test_trace
    import test_trace_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] test_in,
    input  logic             sample_en,
    input  logic             arm,
    input  logic             abort,
    input  logic [1:0]       trig_mode,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [AW:0]      post_cnt,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       state,
    output logic             triggered,
    output logic             done,
    output logic [AW:0]      fill
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [AW-1:0]    wp;
    logic [AW:0]      rem;
    logic [WIDTH-1:0] prev;
    logic             hit;
    logic             capt;
    logic [AW:0]      eff_post;
    logic [AW-1:0]    phys;
    logic             rd_ok;
    logic [WIDTH-1:0] ram_q;

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            TM_MATCH:    hit = ((test_in ^ trig_value) & trig_mask) == '0;
            TM_MISMATCH: hit = ((test_in ^ trig_value) & trig_mask) != '0;
            TM_CHANGE:   hit = ((test_in ^ prev) & trig_mask) != '0;
            TM_IMM:      hit = 1'b1;
        endcase
    end

    always_comb begin
        eff_post = post_cnt;
        if (post_cnt == '0)  eff_post = ONE;
        if (post_cnt > FULL) eff_post = FULL;
    end

    // arm/abort take the cycle, so a sample in that cycle is dropped
    assign capt = sample_en && !abort && !arm &&
                  (state == ST_ARMED || state == ST_POST);

    // once wrapped, the write pointer sits on the oldest entry
    assign phys = (fill == FULL ? wp : '0) + rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wp        <= '0;
            fill      <= '0;
            triggered <= 1'b0;
            rem       <= '0;
            prev      <= '0;
            rd_ok     <= 1'b0;
        end else begin
            rd_ok <= {1'b0, rd_addr} < fill;
            if (sample_en) prev <= test_in;
            if (capt) begin
                wp <= wp + 1'b1;
                if (fill != FULL) fill <= fill + 1'b1;
            end
            if (abort) begin
                state <= ST_IDLE;
            end else if (arm) begin
                state     <= ST_ARMED;
                wp        <= '0;
                fill      <= '0;
                triggered <= 1'b0;
            end else if (capt) begin
                if (state == ST_ARMED) begin
                    if (hit) begin
                        triggered <= 1'b1;
                        rem       <= eff_post - 1'b1;
                        state     <= (eff_post == ONE) ? ST_DONE : ST_POST;
                    end
                end else begin
                    rem <= rem - 1'b1;
                    if (rem == ONE) state <= ST_DONE;
                end
            end
        end
    end

    test_trace_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (capt),
        .waddr(wp),
        .wdata(test_in),
        .raddr(phys),
        .rdata(ram_q)
    );

    assign rd_data = rd_ok ? ram_q : '0;
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_test_trace.sv
// Randomized and directed bench for test_trace against a queue-based
// model of the stored sample history.
module tb_test_trace;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  test_in;
    logic          sample_en;
    logic          arm;
    logic          abort;
    logic [1:0]    trig_mode;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic [AW:0]   post_cnt;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [1:0]    state;
    logic          triggered;
    logic          done;
    logic [AW:0]   fill;

    always #1 clk = ~clk;

    test_trace #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .test_in   (test_in),
        .sample_en (sample_en),
        .arm       (arm),
        .abort     (abort),
        .trig_mode (trig_mode),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
        .post_cnt  (post_cnt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .state     (state),
        .triggered (triggered),
        .done      (done),
        .fill      (fill)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: the last D stored samples, oldest first, plus state and countdown
    logic [31:0] mq[$];
    int          m_state;
    bit          m_trig;
    int          m_rem;
    logic [31:0] m_prev;
    logic [31:0] m_rd;

    task automatic cyc(input logic [31:0] te, input logic se);
        logic        hit;
        logic [31:0] d;
        int          ep;
        test_in   = te;
        sample_en = se;
        if (reset) begin
            mq.delete();
            m_state = 0;
            m_trig  = 0;
            m_rem   = 0;
            m_prev  = 0;
            m_rd    = 0;
        end else begin
            m_rd = (int'(rd_addr) < mq.size()) ? mq[rd_addr] : 32'd0;
            if (trig_mode == 2'd2) d = (te ^ m_prev) & trig_mask;
            else                   d = (te ^ trig_value) & trig_mask;
            case (trig_mode)
                2'd0:    hit = (d == 0);
                2'd1:    hit = (d != 0);
                2'd2:    hit = (d != 0);
                default: hit = 1'b1;
            endcase
            if (abort) begin
                m_state = 0;
            end else if (arm) begin
                m_state = 1;
                m_trig  = 0;
                mq.delete();
            end else if (se && (m_state == 1 || m_state == 2)) begin
                mq.push_back(te);
                if (mq.size() > D) void'(mq.pop_front());
                if (m_state == 1) begin
                    if (hit) begin
                        m_trig = 1;
                        ep = (post_cnt == 0) ? 1 : (post_cnt > D ? D : int'(post_cnt));
                        m_rem = ep - 1;
                        m_state = (m_rem == 0) ? 3 : 2;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
            end
            if (se) m_prev = te;
        end
        @(posedge clk);
        @(negedge clk);
        check("state", state, m_state);
        check("fill", fill, mq.size());
        check("triggered", triggered, m_trig);
        check("done", done, m_state == 3);
        check("rd_data", rd_data, m_rd);
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0;
        test_in = '0; sample_en = 1'b0;
        trig_mode = 2'd0; trig_mask = '0; trig_value = '0;
        post_cnt = '0; rd_addr = '0;

        repeat (5) cyc(0, 0);
        reset = 1'b0;
        cyc(0, 0);
        check("rst_state", state, 0);
        check("rst_fill", fill, 0);
        check("rst_rd", rd_data, 0);
        check("rst_done", done, 0);

        // match on 5, three samples from the trigger
        trig_mode = 2'd0; trig_mask = '1; trig_value = 5; post_cnt = 3;
        arm = 1'b1;
        cyc(32'hAA, 1);
        for (int i = 1; i <= 30 && !done; i++) cyc(i, 1);
        check("match_done", done, 1);
        check("match_fill", fill, 7);
        for (int i = 0; i < 7; i++) begin
            rd_addr = AW'(i);
            cyc(0, 0);
            check("match_rd", rd_data, i + 1);
        end

        // wrap past the buffer size
        trig_value = 40; post_cnt = 4;
        arm = 1'b1;
        cyc(0, 0);
        for (int i = 1; i <= 60 && !done; i++) cyc(i, 1);
        check("wrap_fill", fill, 16);
        rd_addr = 0;
        cyc(0, 0);
        check("wrap_rd0", rd_data, 28);
        rd_addr = 15;
        cyc(0, 0);
        check("wrap_rd15", rd_data, 43);
        rd_addr = 0;
        arm = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        check("rearm_fill", fill, 0);
        check("rearm_rd0", rd_data, 0);

        // masked change on bit 0, post_cnt 0 means a single sample
        trig_mode = 2'd2; trig_mask = 32'h1; post_cnt = 0;
        arm = 1'b1;
        cyc(2, 1);
        repeat (3) cyc(2, 1);
        check("chg_armed", state, 1);
        cyc(3, 1);
        check("chg_done", done, 1);
        check("chg_fill", fill, 4);

        // qualified samples only; post_cnt 20 clamps to 16
        trig_mode = 2'd0; trig_mask = '1; trig_value = 10; post_cnt = 20;
        arm = 1'b1;
        cyc(0, 0);
        for (int i = 1; i <= 80 && !done; i++) cyc(i, (i % 2) == 0);
        check("gap_done", done, 1);
        check("gap_fill", fill, 16);
        rd_addr = 0;
        cyc(0, 0);
        check("gap_rd0", rd_data, 10);
        rd_addr = 15;
        cyc(0, 0);
        check("gap_rd15", rd_data, 40);

        // abort wins over arm
        arm = 1'b1;
        cyc(0, 0);
        check("armed", state, 1);
        arm = 1'b1; abort = 1'b1;
        cyc(0, 0);
        check("abort_arm", state, 0);

        // re-arm in POST
        trig_mode = 2'd3; post_cnt = 10;
        arm = 1'b1;
        cyc(0, 0);
        cyc(7, 1);
        cyc(8, 1);
        check("post_state", state, 2);
        arm = 1'b1;
        cyc(9, 1);
        check("rearm_state", state, 1);
        check("rearm_fill2", fill, 0);
        check("rearm_trig", triggered, 0);

        // abort keeps a partial capture readable
        cyc(1, 1);
        cyc(2, 1);
        abort = 1'b1;
        cyc(3, 1);
        check("abort_state", state, 0);
        check("abort_fill", fill, 2);
        rd_addr = 1;
        cyc(0, 0);
        check("abort_rd1", rd_data, 2);

        // reset in POST
        arm = 1'b1;
        cyc(0, 0);
        cyc(5, 1);
        cyc(6, 1);
        reset = 1'b1;
        cyc(0, 0);
        check("rpost_state", state, 0);
        check("rpost_fill", fill, 0);
        check("rpost_trig", triggered, 0);
        check("rpost_done", done, 0);
        check("rpost_rd", rd_data, 0);
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            trig_mode  = 2'($urandom_range(0, 3));
            trig_mask  = $urandom;
            trig_value = $urandom_range(0, 7);
            post_cnt   = 5'($urandom_range(0, 31));
            rd_addr    = 4'($urandom_range(0, 15));
            arm        = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
